pingpong_sample_store: RTL

- Parametrised successor of the receive-side sample store.
- Decimates the incoming I/Q stream by a programmable factor and writes it into a two-bank (ping-pong) RAM.
- Raises a one-cycle read request each time a bank fills.
- Serves DSP reads from the opposite bank in coarse or fine stride mode, with in-bank wrap and overrun detection.
- Sits between the 50 MHz demod front end and the McBSP/DSP read path.

---
 rtl/pingpong_store_pkg.sv | 22 ++
 rtl/pingpong_store_ram.sv | 34 +++
 rtl/pingpong_sample_store.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pingpong_store_pkg.sv
// Shared definitions for the ping-pong receive sample store.
//   bank_e     : bank-select encoding (BANK0 = 0, BANK1 = 1)
//   *_DEF      : default geometry and decimation constants
//   bank_base(): absolute RAM base address of a bank
package pingpong_store_pkg;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  localparam int unsigned BANK_LEN_DEF     = 52000;
  localparam int unsigned BANK1_BASE_DEF   = 54000;
  localparam int unsigned DECIM_DEF        = 250;
  localparam int unsigned STROBE_PHASE_DEF = 100;

  // Bank 0 always starts at address 0; bank 1 base is a module parameter.
  function automatic int unsigned bank_base(input bank_e bank, input int unsigned bank1_base);
    return (bank == BANK1) ? bank1_base : 0;
  endfunction

endpackage

// File: rtl/pingpong_store_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered (1-cycle) read. Read-during-write to the same address returns
// the old word.
//   clk_50m   : clock
//   cfg_rst_n : async active-low reset, clears the read data register only
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, rdata valid one cycle after raddr
module pingpong_store_ram
  import pingpong_store_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_50m,
  input  logic              cfg_rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_50m) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n) rdata <= '0;
    else            rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_sample_store.sv
// Receive-side ping-pong sample store. Decimates the I/Q stream, writes it
// alternately into two RAM banks, requests a DSP read whenever a bank fills
// and serves reads from the opposite bank in coarse or fine stride.
//   clk_50m, cfg_rst_n        : clock, async active-low reset
//   sample_i, sample_q        : I/Q input samples
//   slot_start_count          : runs the decimation counter (low holds it at 0)
//   init_rx_slot              : restart writing at bank 0 / offset 0, arm requests
//   start_send, send_step     : async level; rising edge loads the read pointer
//   data_updated              : async level; rising edge advances the read pointer
//   part_syn_start            : pulse, enters fine stride mode
//   part_syn_en               : fine stride mode active
//   read_quest, full_bank     : one-cycle bank-full request and its bank
//   data_dsp                  : RAM read data {Q,I}
//   overrun                   : sticky, writer entered the bank being read
//   dbg_wr_addr, dbg_rd_addr  : current write / read RAM addresses
module pingpong_sample_store
  import pingpong_store_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned BANK_LEN     = BANK_LEN_DEF,
  parameter int unsigned BANK1_BASE   = BANK1_BASE_DEF,
  parameter int unsigned DECIM        = DECIM_DEF,
  parameter int unsigned STROBE_PHASE = STROBE_PHASE_DEF,
  parameter int unsigned COARSE_STEP  = 8,
  parameter int unsigned FINE_STEP    = 1,
  parameter int unsigned FINE_END     = 4799
) (
  input  logic                clk_50m,
  input  logic                cfg_rst_n,
  input  logic [DATA_W-1:0]   sample_i,
  input  logic [DATA_W-1:0]   sample_q,
  input  logic                slot_start_count,
  input  logic                init_rx_slot,
  input  logic                start_send,
  input  logic [ADDR_W-1:0]   send_step,
  input  logic                data_updated,
  input  logic                part_syn_start,
  output logic                part_syn_en,
  output logic                read_quest,
  output logic                full_bank,
  output logic [2*DATA_W-1:0] data_dsp,
  output logic                overrun,
  output logic [ADDR_W-1:0]   dbg_wr_addr,
  output logic [ADDR_W-1:0]   dbg_rd_addr
);

  localparam int unsigned       CNT_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(BANK_LEN - 1);

  // Bank-relative offset reduced into 0..BANK_LEN-1.
  function automatic logic [ADDR_W-1:0] wrap_off(input int unsigned v);
    return ADDR_W'(v % BANK_LEN);
  endfunction

  logic [CNT_W-1:0]    dec_cnt;
  logic                wr_stb;
  logic [2*DATA_W-1:0] wr_data_p1;
  logic                wr_vld_p1;
  logic [ADDR_W-1:0]   wr_off;
  bank_e               wr_bank;
  logic                arm;
  logic                ram_we;
  logic [2:0]          send_sync;
  logic [2:0]          upd_sync;
  logic                send_pls;
  logic                upd_pls;
  logic [ADDR_W-1:0]   rd_off;
  bank_e               rd_bank;
  logic                sent;
  int unsigned         rd_step;

  // ---- stage p0: decimation strobe ----
  assign wr_stb = slot_start_count && (dec_cnt == CNT_W'(STROBE_PHASE));

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n)                           dec_cnt <= '0;
    else if (!slot_start_count)               dec_cnt <= '0;
    else if (dec_cnt == CNT_W'(DECIM - 1))    dec_cnt <= '0;
    else                                      dec_cnt <= dec_cnt + CNT_W'(1);
  end

  // ---- stage p1: captured sample, written to RAM on this cycle ----
  always_ff @(posedge clk_50m) begin
    if (wr_stb && !init_rx_slot) wr_data_p1 <= {sample_q, sample_i};
  end

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n) wr_vld_p1 <= 1'b0;
    else            wr_vld_p1 <= wr_stb && !init_rx_slot;
  end

  // init_rx_slot also cancels a write already pending in p1.
  assign ram_we      = wr_vld_p1 && !init_rx_slot;
  assign dbg_wr_addr = ADDR_W'(bank_base(wr_bank, BANK1_BASE)) + wr_off;

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      wr_off     <= '0;
      wr_bank    <= BANK0;
      arm        <= 1'b0;
      read_quest <= 1'b0;
      full_bank  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      read_quest <= 1'b0;
      if (init_rx_slot) begin
        wr_off  <= '0;
        wr_bank <= BANK0;
        arm     <= 1'b1;
        overrun <= 1'b0;
      end else if (wr_vld_p1) begin
        if (wr_off == WR_LAST) begin
          wr_off  <= '0;
          wr_bank <= bank_e'(~wr_bank);
          if (arm) begin
            read_quest <= 1'b1;
            full_bank  <= wr_bank;
          end
          // Writer is about to enter the bank the DSP is reading.
          if (sent && (bank_e'(~wr_bank) == rd_bank)) overrun <= 1'b1;
        end else begin
          wr_off <= wr_off + ADDR_W'(1);
        end
      end
    end
  end

  // ---- read side: synchronised edge pulses and read pointer ----
  // [0],[1] form the synchroniser, [2] holds the previous synchronised level.
  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      send_sync <= '0;
      upd_sync  <= '0;
    end else begin
      send_sync <= {send_sync[1:0], start_send};
      upd_sync  <= {upd_sync[1:0], data_updated};
    end
  end

  assign send_pls = send_sync[1] && !send_sync[2];
  assign upd_pls  = upd_sync[1] && !upd_sync[2];
  assign rd_step  = part_syn_en ? FINE_STEP : COARSE_STEP;

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      rd_off      <= '0;
      rd_bank     <= BANK0;
      sent        <= 1'b0;
      part_syn_en <= 1'b0;
    end else begin
      if (send_pls) begin
        rd_bank <= bank_e'(~wr_bank);
        rd_off  <= wrap_off(32'(send_step));
        sent    <= 1'b1;
      end else if (upd_pls) begin
        rd_off  <= wrap_off(32'(rd_off) + rd_step);
      end
      // Set beats both the end-of-fine clear and a send.
      if (part_syn_start)
        part_syn_en <= 1'b1;
      else if (send_pls || (part_syn_en && rd_off == ADDR_W'(FINE_END)))
        part_syn_en <= 1'b0;
    end
  end

  assign dbg_rd_addr = ADDR_W'(bank_base(rd_bank, BANK1_BASE)) + rd_off;

  pingpong_store_ram #(
    .WORD_W (2*DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_50m   (clk_50m),
    .cfg_rst_n (cfg_rst_n),
    .we        (ram_we),
    .waddr     (dbg_wr_addr),
    .wdata     (wr_data_p1),
    .raddr     (dbg_rd_addr),
    .rdata     (data_dsp)
  );

endmodule
